// File: rtl/weightmemory_pkg.sv
// Shared types and constants for the weightmemory bank scheduler.
//   sched_state_e         : scheduler FSM states
//   phys_bits_per_word()  : encoded word width from N_I and WEIGHT_STAGGER
//   DefaultStarveLimit    : default consecutive-write cap while a read waits
package weightmemory_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StDrain = 2'd2
    } sched_state_e;

    localparam int unsigned DefaultStarveLimit = 4;

    // Each N_I slice is packed in groups of five, one byte per group.
    function automatic int unsigned phys_bits_per_word(input int unsigned n_i,
                                                       input int unsigned stagger);
        return ((n_i / stagger + 4) / 5) * 8;
    endfunction

endpackage

// File: rtl/weightmemory_arbiter.sv
// Single-port grant logic between the write stream and pending burst reads.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   wr_valid_i     : a write is offered this cycle
//   rd_pending_i   : the burst sequencer wants to issue a read this cycle
//   wr_grant_o     : write owns the bank port this cycle
//   rd_grant_o     : read owns the bank port this cycle
// Writes win by default; after STARVE_LIMIT write grants against a waiting
// read, one read slot is forced.
module weightmemory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_valid_i,
    input  logic rd_pending_i,
    output logic wr_grant_o,
    output logic rd_grant_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1) > 0 ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [SW-1:0] starve_q, starve_d;
    logic          force_rd;

    always_comb begin
        force_rd   = rd_pending_i && (starve_q == SW'(STARVE_LIMIT));
        rd_grant_o = rd_pending_i && (!wr_valid_i || force_rd);
        wr_grant_o = wr_valid_i && !force_rd;

        starve_d = starve_q;
        if (!rd_pending_i || rd_grant_o) begin
            starve_d = '0;
        end else if (wr_grant_o) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/weightmemory_scheduler.sv
// Sequences and arbitrates the single port of one weightmemory bank.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o : host/DMA write handshake (ready = accepted now)
//   wr_addr_i, wr_data_i  : write address and encoded word
//   start_i, base_addr_i, len_i : read-burst request (sampled in idle only)
//   stall_i               : consumer cannot take a read next cycle
//   busy_o, done_o        : burst in progress / one-cycle completion pulse
//   rd_valid_o, rd_index_o: bank output valid, aligned with bank ready_o
//   mem_*_o               : bank read_enable/write_enable/addr/wdata
// Read and write enables are mutually exclusive by construction.
module weightmemory_scheduler
    import weightmemory_pkg::*;
#(
    parameter int unsigned N_I                 = 512,
    parameter int unsigned WEIGHT_STAGGER      = 8,
    parameter int unsigned BANKDEPTH           = 90,
    parameter int unsigned STARVE_LIMIT        = DefaultStarveLimit,
    parameter int unsigned PHYSICALBITSPERWORD = phys_bits_per_word(N_I, WEIGHT_STAGGER),
    parameter int unsigned AW                  = $clog2(BANKDEPTH),
    parameter int unsigned LW                  = $clog2(BANKDEPTH + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [PHYSICALBITSPERWORD-1:0] wr_data_i,
    input  logic                           start_i,
    input  logic [AW-1:0]                  base_addr_i,
    input  logic [LW-1:0]                  len_i,
    input  logic                           stall_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           rd_valid_o,
    output logic [LW-1:0]                  rd_index_o,
    output logic                           mem_read_enable_o,
    output logic                           mem_write_enable_o,
    output logic [AW-1:0]                  mem_addr_o,
    output logic [PHYSICALBITSPERWORD-1:0] mem_wdata_o
);

    sched_state_e  state_q;
    logic [AW-1:0] cur_addr_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic          rd_valid_q;
    logic [LW-1:0] rd_index_q;
    logic          zero_done_q;

    logic          rd_pending;
    logic          rd_grant;
    logic          wr_grant;
    logic [AW-1:0] addr_inc;
    logic [LW-1:0] idx_inc;

    // Requests are masked during reset so the bank sees no access while the
    // scheduler is being cleared.
    always_comb begin
        rd_pending = !rst_i && (state_q == StBurst) && (idx_q < len_q) && !stall_i;
        addr_inc   = (cur_addr_q == AW'(BANKDEPTH - 1)) ? '0 : cur_addr_q + AW'(1);
        idx_inc    = idx_q + LW'(1);
    end

    weightmemory_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_valid_i   (wr_valid_i && !rst_i),
        .rd_pending_i (rd_pending),
        .wr_grant_o   (wr_grant),
        .rd_grant_o   (rd_grant)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_index_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            // Bank data appears one cycle after the read is issued.
            rd_valid_q  <= rd_grant;
            rd_index_q  <= rd_grant ? idx_q : '0;
            zero_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            cur_addr_q <= base_addr_i;
                            len_q      <= len_i;
                            idx_q      <= '0;
                            state_q    <= StBurst;
                        end else begin
                            zero_done_q <= 1'b1;
                        end
                    end
                end
                StBurst: begin
                    if (rd_grant) begin
                        cur_addr_q <= addr_inc;
                        idx_q      <= idx_inc;
                        if (idx_inc == len_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy_o             = (state_q != StIdle);
        done_o             = (state_q == StDrain) || zero_done_q;
        rd_valid_o         = rd_valid_q;
        rd_index_o         = rd_index_q;
        wr_ready_o         = wr_grant;
        mem_read_enable_o  = rd_grant;
        mem_write_enable_o = wr_grant;
        mem_addr_o         = '0;
        mem_wdata_o        = '0;
        if (rd_grant) begin
            mem_addr_o = cur_addr_q;
        end else if (wr_grant) begin
            mem_addr_o  = wr_addr_i;
            mem_wdata_o = wr_data_i;
        end
    end

endmodule

// File: doc/weightmemory_scheduler.md
Name: weightmemory_scheduler

Overview:
- Sequences and arbitrates access to one weightmemory bank.
- Shares the bank's single port between the weight-load (write) stream from the host/DMA and read bursts requested by the OCU compute sequencer.
- Never asserts read and write in the same cycle, so the bank's rw_collision_o stays low by construction.
- Generates burst addresses, with wrap-around, and a one-cycle-delayed read-valid tag aligned with the bank's ready_o.

Parameters:
- N_I, 512, input channels
- WEIGHT_STAGGER, 8, words per N_I slice
- BANKDEPTH, 90, words in bank
- STARVE_LIMIT, 4, max consecutive write grants while a read is pending before one read slot is forced
- PHYSICALBITSPERWORD, derived (((N_I/WEIGHT_STAGGER+4)/5)*8), encoded word width
- AW, derived $clog2(BANKDEPTH), address width
- LW, derived $clog2(BANKDEPTH+1), burst-length width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted this cycle (valid&ready)
- wr_addr_i  in  AW  write address
- wr_data_i  in  PHYSICALBITSPERWORD  encoded write word
- start_i  in  1  read-burst start pulse
- base_addr_i  in  AW  burst start address
- len_i  in  LW  burst length in words
- stall_i  in  1  consumer cannot accept a read next cycle
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse, burst complete
- rd_valid_o  out  1  bank output valid this cycle
- rd_index_o  out  LW  word index within burst for rd_valid_o
- mem_read_enable_o  out  1  to bank read_enable_i
- mem_write_enable_o  out  1  to bank write_enable_i
- mem_addr_o  out  AW  to bank addr_i
- mem_wdata_o  out  PHYSICALBITSPERWORD  to bank wdata_i

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters 0.
- Reset mid-burst aborts the burst. No done_o is issued, and any pending rd_valid_o is dropped.
- FSM IDLE: start_i with len_i>0 latches base and len, sets idx=0, goes to BURST.
- start_i with len_i==0 in IDLE: no reads issued, done_o pulses the next cycle, FSM stays in IDLE.
- start_i outside IDLE is ignored.
- FSM BURST: a read is pending when idx<len and stall_i=0.
  - Granted read: mem_read_enable_o=1, mem_addr_o=cur_addr.
  - cur_addr increments and wraps BANKDEPTH-1 -> 0.
  - idx increments.
  - When the last word is issued, go to DRAIN.
- FSM DRAIN: one cycle. Here rd_valid_o covers the last word and done_o=1; then IDLE.
- busy_o=1 in BURST and DRAIN.
- Arbitration is combinational per cycle.
  - Write wins by default: wr_ready_o=wr_valid_i, mem_write_enable_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i.
  - starve_cnt increments on each write grant while a read is pending.
  - When starve_cnt==STARVE_LIMIT and a read is pending, the read is granted, wr_ready_o=0, and starve_cnt clears.
  - starve_cnt also clears on any read grant or when no read is pending.
- mem_wdata_o is 0 when not writing.
- Exactly one or zero of mem_read_enable_o/mem_write_enable_o is high in any cycle.
- Read latency: rd_valid_o and rd_index_o are registered copies of read-grant and issued idx, one cycle after issue. This coincides with bank ready_o and weights_o.
- The consumer must take every rd_valid_o beat. stall_i only suppresses new issues.
- Writes to addresses inside an active burst range are not checked. Ordering is by grant cycle.
- Writes are accepted in every FSM state.

Decomposition:
- Package weightmemory_pkg holds:
  - typedef sched_state_e {IDLE, BURST, DRAIN}
  - function for PHYSICALBITSPERWORD
  - default STARVE_LIMIT constant
- Sub-module weightmemory_arbiter: combinational grant logic plus starve counter, with inputs wr_valid and rd_pending and outputs wr_grant and rd_grant.
- The FSM, address generator and valid pipeline stay in the top.

Test Plan:
- Burst base=10, len=5, no writes, stall_i=0:
  - reads issue at addr 10..14 on cycles 1..5.
  - rd_valid_o with rd_index_o 0..4 on cycles 2..6.
  - done_o on cycle 6; busy_o low on cycle 7.
- Wrap: base=87, len=6 -> addresses 87, 88, 89, 0, 1, 2.
- Write starvation: burst len=3 plus wr_valid_i held high, STARVE_LIMIT=4:
  - pattern W,W,W,W,R repeats.
  - mem_read_enable_o and mem_write_enable_o are never both 1.
  - exactly 3 reads are issued.
- stall_i high for cycles 2-4 of a len=4 burst: no issues during the stall, indices remain contiguous, done_o is delayed by 3 cycles.
- len=0 start -> done_o next cycle, no mem_read_enable_o. start_i during BURST is ignored (count of reads unchanged).
- rst_i asserted at burst idx=2 -> next cycle all outputs 0, no done_o. A new start then runs normally from idx 0.
